// File: rtl/mips_pkg.sv
// Shared definitions for the mips core: register-file geometry, named
// architectural registers and the common word/register-number types.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_num_t;
  typedef logic [REG_DATA_W-1:0] word_t;

  localparam reg_num_t REG_ZERO = 5'd0;
  localparam reg_num_t REG_SP   = 5'd29;
  localparam reg_num_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read port: selects one register from the array and forces
// the hard-wired zero register to read as 0.
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] num,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (num != ADDR_W'(REG_ZERO) && int'(num) < NUM_REGS) begin
      data = regs[num];
    end
  end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two
// asynchronous read ports, register 0 reads as zero and ignores writes.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd0_num,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [DATA_W-1:0] rd1_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_hit;

  // Register 0 is never written, so it stays at its reset value of zero.
  assign wr_hit = wr_en && (wr_num != ADDR_W'(REG_ZERO)) && (int'(wr_num) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_num] <= wr_data;
    end
  end

  // No write bypass: reads see the array as it stood before the edge.
  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd0 (
    .regs (regs),
    .num  (rd0_num),
    .data (rd0_data)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd1 (
    .regs (regs),
    .num  (rd1_num),
    .data (rd1_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// compared against an array-based model of the architectural registers.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic [4:0]  rd0_num;
  logic [31:0] rd0_data;
  logic [4:0]  rd1_num;
  logic [31:0] rd1_data;

  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  reg_file dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_num   (wr_num),
    .wr_data  (wr_data),
    .rd0_num  (rd0_num),
    .rd0_data (rd0_data),
    .rd1_num  (rd1_num),
    .rd1_data (rd1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] n);
    return (n == 5'd0) ? 32'h0 : model[n];
  endfunction

  // One rising edge: the model follows the architectural write/reset rules.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_en && wr_num != 5'd0) begin
      model[wr_num] = wr_data;
    end
    #1;
  endtask

  task automatic check_reads(input logic [4:0] a0, input logic [4:0] a1, input string tag);
    rd0_num = a0;
    rd1_num = a1;
    #1;
    check({tag, "_rd0"}, rd0_data, expect_rd(a0));
    check({tag, "_rd1"}, rd1_data, expect_rd(a1));
  endtask

  task automatic do_write(input logic [4:0] n, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_num  = n;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; wr_en = 1'b0; wr_num = '0; wr_data = '0; rd0_num = '0; rd1_num = '0;

    // Reset clears every register on both ports.
    cycle();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      check_reads(5'(a), 5'(31 - a), "reset");
      check("reset_const", rd0_data, 32'h0);
    end

    // Write then read.
    do_write(5'd29, 32'h80120000);
    do_write(5'd31, 32'h00000000);
    do_write(5'd5,  32'hDEADBEEF);
    check_reads(5'd29, 5'd5, "wr_rd");
    check("wr_rd_r29", rd0_data, 32'h80120000);
    check("wr_rd_r5",  rd1_data, 32'hDEADBEEF);
    check_reads(5'd31, 5'd31, "wr_rd_r31");

    // Zero register ignores writes.
    do_write(5'd0, 32'hFFFFFFFF);
    check_reads(5'd0, 5'd0, "zero");
    check("zero_rd0", rd0_data, 32'h0);
    check("zero_rd1", rd1_data, 32'h0);

    // Write enable low leaves R7 alone.
    wr_en = 1'b0; wr_num = 5'd7; wr_data = 32'h12345678;
    cycle();
    check_reads(5'd7, 5'd7, "wen_low");
    check("wen_low_r7", rd0_data, 32'h0);

    // Same-cycle read/write: old value before the edge, new value after.
    do_write(5'd3, 32'h11111111);
    wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h22222222;
    check_reads(5'd3, 5'd3, "rw_pre");
    check("rw_pre_rd0", rd0_data, 32'h11111111);
    check("rw_pre_rd1", rd1_data, 32'h11111111);
    cycle();
    wr_en = 1'b0;
    check_reads(5'd3, 5'd3, "rw_post");
    check("rw_post_rd0", rd0_data, 32'h22222222);
    check("rw_post_rd1", rd1_data, 32'h22222222);

    // Back-to-back writes to one register: each value visible for a cycle.
    wr_en = 1'b1; wr_num = 5'd10; wr_data = 32'hA5A5A5A5;
    cycle();
    check_reads(5'd10, 5'd10, "b2b_a");
    check("b2b_a_const", rd0_data, 32'hA5A5A5A5);
    wr_data = 32'h5A5A5A5A;
    cycle();
    wr_en = 1'b0;
    check_reads(5'd10, 5'd10, "b2b_b");
    check("b2b_b_const", rd1_data, 32'h5A5A5A5A);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 39) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_num  = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      check_reads(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
      cycle();
    end
    reset = 1'b0; wr_en = 1'b0;
    for (int a = 0; a < 32; a++) check_reads(5'(a), 5'(a), "rand_final");

    // Reset wins over a simultaneous write.
    do_write(5'd9, 32'h01010101);
    reset = 1'b1; wr_en = 1'b1; wr_num = 5'd9; wr_data = 32'hCAFEF00D;
    cycle();
    reset = 1'b0; wr_en = 1'b0;
    check_reads(5'd9, 5'd29, "rst_vs_wr");
    check("rst_vs_wr_r9", rd0_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd0_num = 5'(a);
      #1;
      check("rst_vs_wr_all", rd0_data, 32'h0);
    end

    // Writes resume immediately after reset deasserts.
    do_write(5'd31, 32'h00400000);
    check_reads(5'd31, 5'd0, "post_rst");
    check("post_rst_r31", rd0_data, 32'h00400000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
